// File: rtl/rtc_wr_pkg.sv
// Shared types and constants for the RTC field-edit / write sequencer:
// FSM state encoding, field index map, field-to-register address table and
// packed-BCD single-step helpers.
package rtc_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EDIT     = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } wr_state_e;

  // Field index map
  localparam int FIELD_SEC      = 0;
  localparam int FIELD_MIN      = 1;
  localparam int FIELD_HOUR     = 2;
  localparam int FIELD_DOW      = 3;
  localparam int FIELD_DATE     = 4;
  localparam int FIELD_MONTH    = 5;
  localparam int FIELD_YEAR     = 6;
  localparam int FIELD_TMR_MIN  = 7;
  localparam int FIELD_TMR_HOUR = 8;

  localparam int NUM_ADDR = 9;

  // RTC register address for each field index
  localparam logic [7:0] FIELD_ADDR [NUM_ADDR] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h11
  };

  // Two-digit packed-BCD increment (no range wrap; caller handles limits)
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Two-digit packed-BCD decrement (no range wrap; caller handles limits)
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_bcd_step.sv
// Combinational single BCD step for the edit register.
// Generic mode: up/down with wrap between i_min and i_max.
// 12h mode: value is {b7, 1, pm, hour[4:0]} with hours 01..12; 11<->12
// toggles pm, 12 up wraps to 01 and 01 down wraps to 12.
// Simultaneous up and down (or neither) leaves the value unchanged.
module rtc_bcd_step
  import rtc_wr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_value,
  input  logic [DATA_W-1:0] i_min,
  input  logic [DATA_W-1:0] i_max,
  input  logic              i_up,
  input  logic              i_down,
  input  logic              i_is_12h,
  output logic [DATA_W-1:0] o_value
);

  logic [4:0] w_hour;
  logic [4:0] w_hour_next;
  logic       w_pm_next;

  // Next value for one button step in either generic or 12h format
  always_comb begin
    o_value     = i_value;
    w_hour      = i_value[4:0];
    w_hour_next = i_value[4:0];
    w_pm_next   = i_value[5];
    if (i_is_12h) begin
      if (i_up && !i_down) begin
        if (w_hour == 5'h12) begin
          w_hour_next = 5'h01;
        end else if (w_hour == 5'h11) begin
          w_hour_next = 5'h12;
          w_pm_next   = ~i_value[5];
        end else if (w_hour[3:0] >= 4'd9) begin
          w_hour_next = {1'b1, 4'd0};
        end else begin
          w_hour_next = {w_hour[4], w_hour[3:0] + 4'd1};
        end
      end else if (i_down && !i_up) begin
        if (w_hour <= 5'h01) begin
          w_hour_next = 5'h12;
        end else if (w_hour == 5'h12) begin
          w_hour_next = 5'h11;
          w_pm_next   = ~i_value[5];
        end else if (w_hour[3:0] == 4'd0) begin
          w_hour_next = {1'b0, 4'd9};
        end else begin
          w_hour_next = {w_hour[4], w_hour[3:0] - 4'd1};
        end
      end else begin
        w_hour_next = w_hour;
      end
      o_value = {i_value[7], 1'b1, w_pm_next, w_hour_next};
    end else begin
      if (i_up && !i_down) begin
        o_value = (i_value >= i_max) ? i_min : bcd_inc(i_value);
      end else if (i_down && !i_up) begin
        o_value = (i_value <= i_min) ? i_max : bcd_dec(i_value);
      end else begin
        o_value = i_value;
      end
    end
  end

endmodule

// File: rtl/rtc_field_writer.sv
// RTC field-edit and write sequencer. Keeps an edit image of NUM_FIELDS BCD
// fields with per-field dirty bits, applies button steps to the open field,
// and on commit writes every dirty field (lowest index first) over a
// req/ack write port.
// Build option: define RTC_WR_12H_EN to treat field HOUR_IDX as a 12h hour
// (bit6 = 12h flag, bit5 = PM, fixed limits 01..12).
module rtc_field_writer
  import rtc_wr_pkg::*;
#(
  parameter int NUM_FIELDS = 9,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int HOUR_IDX   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [$clog2(NUM_FIELDS)-1:0] i_field_sel,
  input  logic                          i_edit_start,
  input  logic                          i_pb_up,
  input  logic                          i_pb_down,
  input  logic                          i_commit,
  input  logic                          i_abort,
  input  logic [DATA_W-1:0]             i_cur_value,
  input  logic [DATA_W-1:0]             i_field_min,
  input  logic [DATA_W-1:0]             i_field_max,
  output logic                          o_wr_req,
  output logic [ADDR_W-1:0]             o_wr_addr,
  output logic [DATA_W-1:0]             o_wr_data,
  input  logic                          i_wr_ack,
  output logic [DATA_W-1:0]             o_edit_value,
  output logic [NUM_FIELDS-1:0]         o_dirty,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int SEL_W = $clog2(NUM_FIELDS);

`ifdef RTC_WR_12H_EN
  localparam logic HOUR_12H = 1'b1;
`else
  localparam logic HOUR_12H = 1'b0;
`endif

  wr_state_e           r_state;
  wr_state_e           w_state_next;

  logic [DATA_W-1:0]   r_image [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] r_dirty;
  logic [DATA_W-1:0]   r_edit_val;
  logic [SEL_W-1:0]    r_edit_idx;
  logic [DATA_W-1:0]   r_pre_image;
  logic                r_pre_dirty;
  logic [SEL_W-1:0]    r_wr_idx;
  logic                r_wr_req;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_done;

  logic                w_any_dirty;
  logic [SEL_W-1:0]    w_low_idx;
  logic [DATA_W-1:0]   w_src_val;
  logic [DATA_W-1:0]   w_load_val;
  logic [DATA_W-1:0]   w_step_val;
  logic                w_load_12h;
  logic                w_edit_12h;
  logic                w_step_en;

  assign w_step_en  = i_pb_up ^ i_pb_down;
  assign w_load_12h = HOUR_12H && (i_field_sel == SEL_W'(HOUR_IDX));
  assign w_edit_12h = HOUR_12H && (r_edit_idx == SEL_W'(HOUR_IDX));

  rtc_bcd_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_value  (r_edit_val),
    .i_min    (i_field_min),
    .i_max    (i_field_max),
    .i_up     (i_pb_up),
    .i_down   (i_pb_down),
    .i_is_12h (w_edit_12h),
    .o_value  (w_step_val)
  );

  // Priority pick of the lowest-indexed dirty field for the write burst
  always_comb begin
    w_any_dirty = 1'b0;
    w_low_idx   = '0;
    for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
      w_low_idx   = r_dirty[k] ? SEL_W'(k) : w_low_idx;
      w_any_dirty = w_any_dirty | r_dirty[k];
    end
  end

  // Value loaded on edit_start: image if already modified, else live value, clamped to limits
  always_comb begin
    w_src_val  = r_dirty[i_field_sel] ? r_image[i_field_sel] : i_cur_value;
    w_load_val = w_src_val;
    if (w_load_12h) begin
      if ((w_src_val[7:6] == 2'b01) && (w_src_val[3:0] <= 4'd9) &&
          (w_src_val[4:0] >= 5'h01) && (w_src_val[4:0] <= 5'h12)) begin
        w_load_val = w_src_val;
      end else begin
        w_load_val = DATA_W'(8'h41);
      end
    end else begin
      if ((w_src_val < i_field_min) || (w_src_val > i_field_max)) begin
        w_load_val = i_field_min;
      end else begin
        w_load_val = w_src_val;
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; COMMIT/WAIT_ACK ignore the panel controls
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_commit) begin
          w_state_next = ST_COMMIT;
        end else if (i_edit_start) begin
          w_state_next = ST_EDIT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (i_commit) begin
          w_state_next = ST_COMMIT;
        end else if (i_abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_EDIT;
        end
      end
      ST_COMMIT: begin
        if (w_any_dirty) begin
          w_state_next = ST_WAIT_ACK;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (i_wr_ack) begin
          w_state_next = ST_COMMIT;
        end else begin
          w_state_next = ST_WAIT_ACK;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Edit image, dirty tracking and registered write-port outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        r_image[k] <= '0;
      end
      r_dirty     <= '0;
      r_edit_val  <= '0;
      r_edit_idx  <= '0;
      r_pre_image <= '0;
      r_pre_dirty <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_req    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_next == ST_COMMIT) || (w_state_next == ST_WAIT_ACK);
      case (r_state)
        ST_IDLE: begin
          if (!i_commit && i_edit_start) begin
            r_edit_val  <= w_load_val;
            r_edit_idx  <= i_field_sel;
            r_pre_image <= r_image[i_field_sel];
            r_pre_dirty <= r_dirty[i_field_sel];
          end
        end
        ST_EDIT: begin
          if (i_commit) begin
            // edits already live in the image; nothing to move
          end else if (i_abort) begin
            r_image[r_edit_idx] <= r_pre_image;
            r_dirty[r_edit_idx] <= r_pre_dirty;
          end else if (i_edit_start) begin
            r_edit_val  <= w_load_val;
            r_edit_idx  <= i_field_sel;
            r_pre_image <= r_image[i_field_sel];
            r_pre_dirty <= r_dirty[i_field_sel];
          end else if (w_step_en) begin
            r_edit_val          <= w_step_val;
            r_image[r_edit_idx] <= w_step_val;
            r_dirty[r_edit_idx] <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (w_any_dirty) begin
            r_wr_req  <= 1'b1;
            r_wr_idx  <= w_low_idx;
            r_wr_addr <= ADDR_W'(FIELD_ADDR[w_low_idx]);
            r_wr_data <= r_image[w_low_idx];
          end else begin
            r_done <= 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (i_wr_ack) begin
            r_dirty[r_wr_idx] <= 1'b0;
            r_wr_req          <= 1'b0;
          end
        end
        default: begin
          r_wr_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_req     = r_wr_req;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_dirty      = r_dirty;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_edit_value = (r_state == ST_EDIT) ? r_edit_val : i_cur_value;

endmodule

// File: tb/tb_rtc_field_writer.sv
// Self-checking bench for rtc_field_writer: directed scenarios plus
// randomized edit sessions and commit bursts against a BCD reference model.
module tb_rtc_field_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] field_sel;
  logic       edit_start, pb_up, pb_down, commit, abort, wr_ack;
  logic [7:0] cur_value, field_min, field_max;
  logic       wr_req, busy, done;
  logic [7:0] wr_addr, wr_data, edit_value;
  logic [8:0] dirty;

  // Live RTC register contents and per-field limits seen by the DUT
  logic [7:0] live [9];
  localparam logic [7:0] LIM_MIN  [9] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
  localparam logic [7:0] LIM_MAX  [9] = '{8'h59, 8'h59, 8'h23, 8'h07, 8'h31, 8'h12, 8'h99, 8'h59, 8'h23};
  localparam logic [7:0] EXP_ADDR [9] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h11};

  assign cur_value = live[field_sel];
  assign field_min = LIM_MIN[field_sel];
  assign field_max = LIM_MAX[field_sel];

  // Reference model state
  logic [7:0] m_image [9];
  logic [8:0] m_dirty;
  logic [7:0] m_edit;
  int         m_idx;
  logic [7:0] m_pre_img;
  logic       m_pre_dirty;

  int errors = 0;
  int checks = 0;

  rtc_field_writer dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_field_sel  (field_sel),
    .i_edit_start (edit_start),
    .i_pb_up      (pb_up),
    .i_pb_down    (pb_down),
    .i_commit     (commit),
    .i_abort      (abort),
    .i_cur_value  (cur_value),
    .i_field_min  (field_min),
    .i_field_max  (field_max),
    .o_wr_req     (wr_req),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .i_wr_ack     (wr_ack),
    .o_edit_value (edit_value),
    .o_dirty      (dirty),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [7:0] model_step(input logic [7:0] v, input int f, input logic up, input logic dn);
    int n;
    n = bcd2int(v);
    if (up && !dn) begin
      if (n + 1 > bcd2int(LIM_MAX[f])) return LIM_MIN[f];
      return int2bcd(n + 1);
    end else if (dn && !up) begin
      if (n - 1 < bcd2int(LIM_MIN[f])) return LIM_MAX[f];
      return int2bcd(n - 1);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_edit_start(input int f);
    logic [7:0] src;
    field_sel  = 4'(f);
    edit_start = 1'b1;
    tick();
    edit_start = 1'b0;
    m_pre_img   = m_image[f];
    m_pre_dirty = m_dirty[f];
    src = m_dirty[f] ? m_image[f] : live[f];
    if (bcd2int(src) < bcd2int(LIM_MIN[f]) || bcd2int(src) > bcd2int(LIM_MAX[f])) src = LIM_MIN[f];
    m_edit = src;
    m_idx  = f;
  endtask

  task automatic press(input logic up, input logic dn);
    pb_up   = up;
    pb_down = dn;
    tick();
    pb_up   = 1'b0;
    pb_down = 1'b0;
    if (up ^ dn) begin
      m_edit = model_step(m_edit, m_idx, up, dn);
      m_image[m_idx] = m_edit;
      m_dirty[m_idx] = 1'b1;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    m_image[m_idx] = m_pre_img;
    m_dirty[m_idx] = m_pre_dirty;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (wr_req !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr: got req=%b addr=%h data=%h expected 0 00 00", wr_req, wr_addr, wr_data);
    end
    checks++;
    if (dirty !== 9'h000 || busy !== 1'b0 || done !== 1'b0 || edit_value !== live[0]) begin
      errors++;
      $display("FAIL reset_state: got dirty=%h busy=%b done=%b ev=%h expected 000 0 0 %h",
               dirty, busy, done, edit_value, live[0]);
    end
    // acknowledge while idle must be ignored
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || dirty !== 9'h000) begin
      errors++;
      $display("FAIL stray_ack: got req=%b busy=%b dirty=%h expected 0 0 000", wr_req, busy, dirty);
    end
  endtask

  task automatic test_seconds_wrap();
    live[0] = 8'h58;
    do_edit_start(0);
    checks++;
    if (edit_value !== 8'h58) begin
      errors++; $display("FAIL sec_load: got %h expected 58", edit_value);
    end
    press(1'b1, 1'b0);
    checks++;
    if (edit_value !== 8'h59) begin
      errors++; $display("FAIL sec_up1: got %h expected 59", edit_value);
    end
    press(1'b1, 1'b0);
    checks++;
    if (edit_value !== 8'h00 || dirty[0] !== 1'b1) begin
      errors++; $display("FAIL sec_wrap: got %h dirty0=%b expected 00 1", edit_value, dirty[0]);
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    checks++;
    if (edit_value !== 8'h00 || dirty !== m_dirty) begin
      errors++; $display("FAIL both_buttons: got %h dirty=%h expected 00 %h", edit_value, dirty, m_dirty);
    end
  endtask

  task automatic test_switch_field();
    live[3] = 8'h03;
    do_edit_start(3);
    press(1'b1, 1'b0);
    checks++;
    if (edit_value !== 8'h04 || dirty !== 9'h009) begin
      errors++; $display("FAIL switch_field: got %h dirty=%h expected 04 009", edit_value, dirty);
    end
  endtask

  task automatic test_commit_burst(input int delay_sel);
    int   exp_q[$];
    int   idx, n_exp, n_wr, n_done, dly;
    logic [7:0] a0, d0;
    bit   fin;
    for (int k = 0; k < 9; k++) if (m_dirty[k]) exp_q.push_back(k);
    n_exp  = exp_q.size();
    n_wr   = 0;
    n_done = 0;
    fin    = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL commit_cycle1: got req=%b busy=%b expected 0 1", wr_req, busy);
    end
    for (int c = 0; c < 200 && !fin; c++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        fin = 1'b1;
      end else if (wr_req === 1'b1) begin
        n_wr++;
        idx = -1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL burst_extra: got write addr=%h expected no write", wr_addr);
        end else begin
          idx = exp_q.pop_front();
          if (wr_addr !== EXP_ADDR[idx] || wr_data !== m_image[idx]) begin
            errors++; $display("FAIL burst_write: got addr=%h data=%h expected %h %h",
                               wr_addr, wr_data, EXP_ADDR[idx], m_image[idx]);
          end
        end
        a0  = wr_addr;
        d0  = wr_data;
        dly = (delay_sel < 0) ? int'($urandom_range(0, 3)) : delay_sel;
        for (int h = 0; h < dly; h++) begin
          edit_start = 1'b1;
          pb_up      = 1'b1;
          abort      = 1'b1;
          tick();
          checks++;
          if (wr_req !== 1'b1 || wr_addr !== a0 || wr_data !== d0 || busy !== 1'b1) begin
            errors++; $display("FAIL burst_hold: got req=%b addr=%h data=%h busy=%b expected 1 %h %h 1",
                               wr_req, wr_addr, wr_data, busy, a0, d0);
          end
        end
        edit_start = 1'b0;
        pb_up      = 1'b0;
        abort      = 1'b0;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        if (idx >= 0) m_dirty[idx] = 1'b0;
        checks++;
        if (wr_req !== 1'b0 || dirty !== m_dirty) begin
          errors++; $display("FAIL burst_ack: got req=%b dirty=%h expected 0 %h", wr_req, dirty, m_dirty);
        end
      end
    end
    checks++;
    if (!fin || n_wr != n_exp || exp_q.size() != 0 || dirty !== 9'h000) begin
      errors++; $display("FAIL burst_end: got done_seen=%0d writes=%0d dirty=%h expected 1 %0d 000",
                         fin, n_wr, dirty, n_exp);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    live[1] = 8'h10;
    do_edit_start(1);
    repeat (20) press(1'b1, 1'b0);
    checks++;
    if (edit_value !== 8'h30 || dirty[1] !== 1'b1) begin
      errors++; $display("FAIL abort_edit: got %h dirty1=%b expected 30 1", edit_value, dirty[1]);
    end
    do_abort();
    checks++;
    if (dirty[1] !== 1'b0 || edit_value !== 8'h10) begin
      errors++; $display("FAIL abort_restore: got dirty1=%b ev=%h expected 0 10", dirty[1], edit_value);
    end
    live[1] = 8'h44;
    do_edit_start(1);
    checks++;
    if (edit_value !== 8'h44) begin
      errors++; $display("FAIL abort_reload: got %h expected 44", edit_value);
    end
    do_abort();
  endtask

`ifdef RTC_WR_12H_EN
  task automatic test_12h();
    logic [7:0] exp_seq [4];
    logic       up_seq  [4];
    exp_seq = '{8'h72, 8'h61, 8'h72, 8'h51};
    up_seq  = '{1'b1, 1'b1, 1'b0, 1'b0};
    live[2]    = 8'h51;
    field_sel  = 4'd2;
    edit_start = 1'b1;
    tick();
    edit_start = 1'b0;
    checks++;
    if (edit_value !== 8'h51) begin
      errors++; $display("FAIL h12_load: got %h expected 51", edit_value);
    end
    for (int s = 0; s < 4; s++) begin
      pb_up   = up_seq[s];
      pb_down = ~up_seq[s];
      tick();
      pb_up   = 1'b0;
      pb_down = 1'b0;
      checks++;
      if (edit_value !== exp_seq[s]) begin
        errors++; $display("FAIL h12_step%0d: got %h expected %h", s, edit_value, exp_seq[s]);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    live[2]    = 8'h13;
    edit_start = 1'b1;
    tick();
    edit_start = 1'b0;
    checks++;
    if (edit_value !== 8'h41 || dirty[2] !== 1'b0) begin
      errors++; $display("FAIL h12_clamp: got %h dirty2=%b expected 41 0", edit_value, dirty[2]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask
`endif

  task automatic test_random_edits();
    int f, nsteps, lo, hi;
    logic u, d;
    for (int it = 0; it < 24; it++) begin
      f = int'($urandom_range(0, 8));
`ifdef RTC_WR_12H_EN
      if (f == 2) f = 3;
`endif
      lo = bcd2int(LIM_MIN[f]);
      hi = bcd2int(LIM_MAX[f]);
      if ($urandom_range(0, 3) == 0 && hi < 99) live[f] = int2bcd(int'($urandom_range(hi + 1, 99)));
      else live[f] = int2bcd(int'($urandom_range(lo, hi)));
      do_edit_start(f);
      checks++;
      if (edit_value !== m_edit) begin
        errors++; $display("FAIL rnd_load: field %0d got %h expected %h", f, edit_value, m_edit);
      end
      nsteps = int'($urandom_range(1, 12));
      for (int s = 0; s < nsteps; s++) begin
        u = 1'($urandom_range(0, 1));
        d = 1'($urandom_range(0, 1));
        press(u, d);
        checks++;
        if (edit_value !== m_edit || dirty !== m_dirty) begin
          errors++; $display("FAIL rnd_step: field %0d got %h dirty=%h expected %h %h",
                             f, edit_value, dirty, m_edit, m_dirty);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        do_abort();
        checks++;
        if (dirty !== m_dirty) begin
          errors++; $display("FAIL rnd_abort: got dirty=%h expected %h", dirty, m_dirty);
        end
      end
      if ((it % 8) == 7) test_commit_burst(-1);
    end
  endtask

  task automatic test_reset_in_wait();
    int waited;
    live[4] = 8'h15;
    do_edit_start(4);
    press(1'b1, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    waited = 0;
    while (wr_req !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (wr_req !== 1'b1 || wr_data !== 8'h16) begin
      errors++; $display("FAIL rst_wait_req: got req=%b data=%h expected 1 16", wr_req, wr_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (wr_req !== 1'b0 || dirty !== 9'h000 || busy !== 1'b0 || edit_value !== live[4]) begin
      errors++; $display("FAIL rst_wait_drop: got req=%b dirty=%h busy=%b ev=%h expected 0 000 0 %h",
                         wr_req, dirty, busy, edit_value, live[4]);
    end
    reset = 1'b1;
    for (int k = 0; k < 9; k++) m_image[k] = 8'h00;
    m_dirty = 9'h000;
    tick();
  endtask

  task automatic test_empty_commit();
    int n_req, n_done;
    n_req  = 0;
    n_done = 0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (wr_req === 1'b1) n_req++;
      if (done === 1'b1) n_done++;
      tick();
    end
    checks++;
    if (n_req != 0 || n_done != 1) begin
      errors++; $display("FAIL empty_commit: got req_cycles=%0d done_pulses=%0d expected 0 1", n_req, n_done);
    end
  endtask

  initial begin
    reset      = 1'b0;
    field_sel  = 4'd0;
    edit_start = 1'b0;
    pb_up      = 1'b0;
    pb_down    = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    wr_ack     = 1'b0;
    for (int k = 0; k < 9; k++) begin
      live[k]    = LIM_MIN[k];
      m_image[k] = 8'h00;
    end
    m_dirty     = 9'h000;
    m_edit      = 8'h00;
    m_idx       = 0;
    m_pre_img   = 8'h00;
    m_pre_dirty = 1'b0;

    test_reset();
    test_seconds_wrap();
    test_simultaneous();
    test_switch_field();
    test_commit_burst(3);
    test_abort();
`ifdef RTC_WR_12H_EN
    test_12h();
`endif
    test_random_edits();
    test_commit_burst(-1);
    test_reset_in_wait();
    test_empty_commit();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_field_writer.md
# rtc_field_writer

Parametrised field-edit and write sequencer for the RTC programming path. It holds an edit image of NUM_FIELDS time/date/timer fields and applies debounced push-button BCD increments and decrements with per-field wrap limits. On commit it issues one handshaked register write per modified field, lowest index first, to the RTC bus controller. It sits between the front-panel controls and the bus-controller write port, and replaces the fixed-width address/data muxing with a dirty-tracked, multi-field write burst.

## Interface
- NUM_FIELDS, 9, number of editable fields (index 0..NUM_FIELDS-1)
- ADDR_W, 8, RTC register address width
- DATA_W, 8, field data width (packed BCD, two digits)
- HOUR_IDX, 2, field index that carries the hour (12h handling)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- field_sel  in  $clog2(NUM_FIELDS)  field selected for editing
- edit_start  in  1  pulse: open field_sel for editing
- pb_up / pb_down  in  1  single-cycle debounced pulses
- commit  in  1  pulse: write all dirty fields
- abort  in  1  pulse: discard the open edit (EDIT state only)
- cur_value  in  DATA_W  live register value of field_sel
- field_min / field_max  in  DATA_W  BCD limits of field_sel
- wr_req  out  1  write request
- wr_addr  out  ADDR_W  target register address
- wr_data  out  DATA_W  data to write
- wr_ack  in  1  single-cycle write acknowledge from the bus controller
- edit_value  out  DATA_W  value shown on the display
- dirty  out  NUM_FIELDS  per-field modified mask
- busy  out  1  high in COMMIT and WAIT_ACK
- done  out  1  one-cycle pulse when a commit burst finishes

## Operation
- States: IDLE, EDIT, COMMIT, WAIT_ACK.
- IDLE, edit_start: the field loads into the edit register. The source is the edit image if the field's dirty bit is set, otherwise cur_value. The machine then moves to EDIT.
- Load clamp: a loaded value outside [field_min, field_max] becomes field_min. The clamp does not set dirty.
- EDIT, pb_up only: BCD increment. The value wraps from field_max to field_min. Low nibble 9 becomes 0 with a carry into the high nibble.
- EDIT, pb_down only: BCD decrement. The value wraps from field_min to field_max.
- EDIT, pb_up and pb_down together: both are ignored.
- Every applied step writes the edit image for the field and sets its dirty bit.
- EDIT, edit_start: the current field stays in the image and the new field_sel loads. The machine stays in EDIT.
- EDIT, abort: the field's image and dirty bit return to their pre-edit values. The machine goes to IDLE.
- IDLE or EDIT, commit: the machine goes to COMMIT.
- COMMIT: selects the lowest-indexed dirty field. It drives wr_addr = FIELD_ADDR[i] and wr_data = image[i], asserts wr_req, and moves to WAIT_ACK.
  - If no field is dirty, it pulses done and goes to IDLE.
- WAIT_ACK: wr_req, wr_addr and wr_data stay stable until wr_ack is sampled high. The machine then clears dirty[i], drops wr_req and returns to COMMIT.
- Inputs ignored during COMMIT and WAIT_ACK: abort, edit_start, pb_up, pb_down and commit. A started write is never cancelled.
- edit_value shows the edit register in EDIT and cur_value otherwise.
- Reset values: state IDLE, wr_req 0, wr_addr 0, wr_data 0, dirty 0, done 0, busy 0, image 0.

## Timing
- edit_start to edit_value valid: 1 cycle.
- Button pulse to updated edit_value: 1 cycle.
- commit to first wr_req high: 2 cycles (one in COMMIT, then wr_req is registered).
- wr_ack to next wr_req: 2 cycles. wr_req is low for at least 1 cycle between writes.
- wr_ack seen outside WAIT_ACK is ignored.
- Reset low during WAIT_ACK: wr_req drops at the same edge and the partial burst is lost.

## Configuration
- RTC_WR_12H_EN defined: field HOUR_IDX uses 12h format, with bit6 = 1 and bit5 = PM.
  - Valid hours are 01..12, and the hour limits are fixed to 01..12. field_min and field_max are ignored for this field.
  - Up from 11 to 12, or down from 12 to 11, toggles bit5.
  - Up from 12 wraps to 01, and down from 01 wraps to 12.
- RTC_WR_12H_EN undefined: the hour field is treated like any other field, using field_min and field_max.

## Structure
- Package rtc_wr_pkg holds:
  - the state enum;
  - the FIELD_ADDR constant array (index to RTC register address);
  - field index constants for seconds through timer-hours.
- Sub-module rtc_bcd_step: combinational BCD up/down with min/max wrap and the 12h variant. Instantiated once on the edit register.

## Test plan
- Seconds field, cur_value 8'h58, max 8'h59, min 8'h00; edit_start then 2× pb_up -> edit_value 8'h59, then 8'h00; dirty[0] = 1.
- Edit fields 0 and 3; commit with wr_ack 3 cycles after each wr_req -> two writes, index 0 then 3, addresses FIELD_ADDR[0] then [3]; dirty becomes 0; done pulses once.
- pb_up and pb_down in the same cycle during EDIT -> edit_value unchanged, dirty unchanged.
- Edit field 1 to 8'h30 from 8'h10, then abort -> dirty[1] = 0; next edit_start loads cur_value.
- RTC_WR_12H_EN, hour 8'h51 (11 AM); pb_up -> 8'h72 (12 PM); pb_up -> 8'h61 (01 PM).
- Reset low while WAIT_ACK with wr_req high -> next cycle wr_req 0, dirty 0, state IDLE; commit with nothing dirty -> done pulse, no wr_req.
